// File: rtl/mem_bus_responder_if.sv
// Split-handshake memory bus (req / addr_ok / data_ok) between the arbiter's
// mem_* request port (master) and the memory-side responder (slave).
interface mem_bus_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_wmask;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_address, mem_wdata, mem_wmask,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_address, mem_wdata, mem_wmask,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder: byte-masked word RAM answering one outstanding request
// at a time after LATENCY cycles. Define RESP_STALL_EN for LFSR backpressure.
module mem_bus_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_bus_responder_if.slave  bus
);
  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_reg;
  logic [3:0]            cnt_reg;
  logic                  data_ok_reg;
  logic                  is_read_reg;
  logic [DATA_WIDTH-1:0] rd_word_reg;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic                  stall;
  logic                  handshake;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  unused_addr_bits;

  // Low byte-offset bits and everything above the RAM depth are dropped, so addresses alias.
  assign word_idx         = bus.mem_address[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{bus.mem_address[1:0], bus.mem_address[ADDR_WIDTH-1:DEPTH_LOG2+2]};

`ifdef RESP_STALL_EN
  logic [7:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_reg <= 8'hA5;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  assign stall = lfsr_reg[0];
`else
  assign stall = 1'b0;
`endif

  assign bus.mem_addr_ok = bus.mem_req && rst_n && !stall &&
                           (state_reg == IDLE || state_reg == RESP);
  assign handshake       = bus.mem_req && bus.mem_addr_ok;

  // RAM write and registered read share the handshake edge; no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (handshake) begin
      if (bus.mem_we) begin
        for (int i = 0; i < MASK_WIDTH; i++) begin
          if (bus.mem_wmask[i]) begin
            ram[word_idx][i*8 +: 8] <= bus.mem_wdata[i*8 +: 8];
          end
        end
      end else begin
        rd_word_reg <= ram[word_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      data_ok_reg <= 1'b0;
      is_read_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, RESP: begin
          if (handshake) begin
            is_read_reg <= !bus.mem_we;
            if (LATENCY == 1) begin
              state_reg   <= RESP;
              data_ok_reg <= 1'b1;
            end else begin
              state_reg   <= WAIT;
              cnt_reg     <= LAT_M1;
              data_ok_reg <= 1'b0;
            end
          end else begin
            state_reg   <= IDLE;
            data_ok_reg <= 1'b0;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg   <= RESP;
            data_ok_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          data_ok_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_data_ok = data_ok_reg;
  // Write responses and idle cycles present zero on the read bus.
  assign bus.mem_rdata   = (data_ok_reg && is_read_reg) ? rd_word_reg : '0;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench: one LATENCY=1 and one LATENCY=3 responder checked against
// a word/byte-mask memory model with directed steps and random traffic.
module tb_mem_bus_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] model_mem [2][4096];
  int          lat [2] = '{1, 3};

  mem_bus_responder_if bus1 ();
  mem_bus_responder_if bus3 ();

  mem_bus_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_bus_responder #(.LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always #5 clk = ~clk;

`ifdef RESP_STALL_EN
  localparam int NRAND = 500;
`else
  localparam int NRAND = 60;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic drive(input int d, input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m);
    if (d == 0) begin
      bus1.mem_req = req; bus1.mem_we = we; bus1.mem_address = a;
      bus1.mem_wdata = wd; bus1.mem_wmask = m;
    end else begin
      bus3.mem_req = req; bus3.mem_we = we; bus3.mem_address = a;
      bus3.mem_wdata = wd; bus3.mem_wmask = m;
    end
  endtask

  function automatic logic get_addr_ok(input int d);
    return (d == 0) ? bus1.mem_addr_ok : bus3.mem_addr_ok;
  endfunction

  function automatic logic get_data_ok(input int d);
    return (d == 0) ? bus1.mem_data_ok : bus3.mem_data_ok;
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? bus1.mem_rdata : bus3.mem_rdata;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 4096);
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] m);
    for (int b = 0; b < 4; b++) begin
      if (m[b]) model_mem[d][word_of(a)][b*8 +: 8] = wd[b*8 +: 8];
    end
  endtask

  // Called right after the request is driven; waits (bounded) for addr_ok.
  task automatic wait_accept(input int d, input string tag, output logic ok);
    int n = 0;
    #1;
    while (!get_addr_ok(d) && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
    ok = get_addr_ok(d);
    check1(tag, ok, 1'b1);
  endtask

  task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input string tag, output logic [31:0] got);
    logic [31:0] exp_rd;
    logic        ok;
    int          n;
    got = '0;
    @(negedge clk);
    drive(d, 1'b1, we, a, wd, m);
    wait_accept(d, {tag, "_accept"}, ok);
    if (!ok) begin
      drive(d, 1'b0, 1'b0, '0, '0, '0);
      return;
    end
    exp_rd = we ? 32'h0 : model_mem[d][word_of(a)];
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, '0, '0, '0);
    if (we) model_write(d, a, wd, m);
    n = 1;
    @(negedge clk);
    while (!get_data_ok(d) && n < 32) begin
      @(negedge clk);
      n++;
    end
    got = get_rdata(d);
    check({tag, "_latency"}, n, lat[d]);
    check({tag, "_rdata"}, got, exp_rd);
    @(negedge clk);
    check1({tag, "_pulse"}, get_data_ok(d), 1'b0);
    $display("txn dut=L%0d we=%0d addr=%h wdata=%h mask=%h rdata=%h lat=%0d",
             lat[d], we, a, wd, m, got, n);
  endtask

  initial begin
    logic [31:0] got;
    logic        ok;
    int          pulses;
    logic [31:0] rd_or;
    logic        b_we [8];
    logic [31:0] b_addr [8];
    logic [31:0] b_wd [8];
    logic [31:0] b_exp [8];

    drive(0, 1'b1, 1'b0, 32'h0, '0, '0);
    drive(1, 1'b0, 1'b0, 32'h0, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    check1("rst_addr_ok", bus1.mem_addr_ok, 1'b0);
    check1("rst_data_ok1", bus1.mem_data_ok, 1'b0);
    check("rst_rdata1", bus1.mem_rdata, 32'h0);
    check1("rst_data_ok3", bus3.mem_data_ok, 1'b0);
    check("rst_rdata3", bus3.mem_rdata, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, '0, '0);
    rst_n = 1'b1;

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "l1_wr10", got);
    check("l1_wr_rdata_zero", got, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "l1_rd10", got);
    check("l1_rd10_const", got, 32'hDEADBEEF);

    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "mask_pre", got);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "mask_wr", got);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, "mask_rd", got);
    check("mask_const", got, 32'h11BB33DD);
    txn(0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, "mask_zero", got);

    txn(0, 1'b1, 32'h10, 32'h5A5A5A5A, 4'hF, "alias_wr", got);
    txn(0, 1'b0, 32'h4010, 32'h0, 4'h0, "alias_rd", got);
    check("alias_const", got, 32'h5A5A5A5A);

`ifndef RESP_STALL_EN
    // Back-to-back on LATENCY=1 with req held: includes a read right after a write to the same word.
    b_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    b_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'h0, 32'h4, 32'h8};
    b_wd   = '{32'd1, 32'd2, 32'd3, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0};
    b_exp  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h77, 32'd1, 32'd2, 32'd3};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check1($sformatf("b2b_dok_%0d", i - 1), bus1.mem_data_ok, 1'b1);
        check($sformatf("b2b_rdata_%0d", i - 1), bus1.mem_rdata, b_exp[i-1]);
      end
      drive(0, 1'b1, b_we[i], b_addr[i], b_wd[i], 4'hF);
      #1;
      check1($sformatf("b2b_aok_%0d", i), bus1.mem_addr_ok, 1'b1);
      if (b_we[i]) model_write(0, b_addr[i], b_wd[i], 4'hF);
      $display("txn dut=L1 b2b step=%0d we=%0d addr=%h wdata=%h", i, b_we[i], b_addr[i], b_wd[i]);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    check1("b2b_dok_7", bus1.mem_data_ok, 1'b1);
    check("b2b_rdata_7", bus1.mem_rdata, b_exp[7]);
    @(negedge clk);
    check1("b2b_end_idle", bus1.mem_data_ok, 1'b0);

    txn(1, 1'b1, 32'h30, 32'hCAFE0030, 4'hF, "l3_wr", got);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h30, '0, '0);
    #1;
    check1("l3_acc", bus3.mem_addr_ok, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      check1($sformatf("l3_dok_%0d", k), bus3.mem_data_ok, k == 3);
      check1($sformatf("l3_aok_%0d", k), bus3.mem_addr_ok, k == 3);
    end
    check("l3_rdata", bus3.mem_rdata, 32'hCAFE0030);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    $display("txn dut=L3 held read addr=00000030 rdata=%h", bus3.mem_rdata);
    @(negedge clk);
    check1("l3_idle", bus3.mem_data_ok, 1'b0);
`else
    txn(1, 1'b1, 32'h30, 32'hCAFE0030, 4'hF, "l3_wr", got);
`endif

    // Reset one cycle after the handshake drops the pending response.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h30, '0, '0);
    wait_accept(1, "rst_acc", ok);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    rd_or = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus3.mem_data_ok) pulses++;
      rd_or = rd_or | bus3.mem_rdata;
    end
    check("rst_no_data_ok", pulses, 0);
    check("rst_rdata_zero", rd_or, 32'h0);
    $display("txn dut=L3 reset mid-read addr=00000030 pulses=%0d", pulses);
    txn(1, 1'b0, 32'h30, 32'h0, 4'h0, "post_rst_rd", got);
    check("post_rst_const", got, 32'hCAFE0030);

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        txn(d, 1'b1, 32'(w * 4), $urandom, 4'hF, "rnd_init", got);
      end
      for (int i = 0; i < NRAND; i++) begin
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_C003) | 32'($urandom_range(0, 15) * 4);
        txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rnd", got);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the core's split-handshake memory bus (req / addr_ok / data_ok). Sits behind the instruction/data bus arbiter and answers the arbiter's mem_* request port. Backs the bus with an internal word-addressed RAM with byte write masks and a configurable response latency. At most one transaction is outstanding, and a new request is accepted in the same cycle the previous response is returned.

## Interface
- ADDR_WIDTH, 32, request address width (byte address)
- DATA_WIDTH, 32, data width
- MASK_WIDTH, 4, byte write-mask width (DATA_WIDTH/8)
- DEPTH_LOG2, 12, log2 of RAM depth in words
- LATENCY, 1, cycles from address handshake to data_ok; legal range 1..15

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- mem_req  in  1  request valid
- mem_we  in  1  1 = write, 0 = read
- mem_address  in  ADDR_WIDTH  byte address
- mem_wdata  in  DATA_WIDTH  write data
- mem_wmask  in  MASK_WIDTH  byte enables; bit i covers wdata[8i+7:8i]
- mem_addr_ok  out  1  request accepted this cycle (combinational)
- mem_data_ok  out  1  one-cycle response pulse (read data valid / write acknowledged)
- mem_rdata  out  DATA_WIDTH  read data, valid only with mem_data_ok

## Operation
- Handshake: a request is accepted when mem_req && mem_addr_ok are both high at a rising edge.
- Word index is mem_address[DEPTH_LOG2+1:2]. Bits [1:0] and bits above DEPTH_LOG2+1 are ignored, so out-of-range addresses alias (wrap).
- States:
  - IDLE: no request outstanding.
  - WAIT: countdown running.
  - RESP: mem_data_ok high.
- mem_addr_ok = mem_req && rst_n && (state==IDLE || state==RESP) && !stall. Outside these conditions it is 0.
- Transitions on a handshake (from IDLE or RESP):
  - LATENCY==1: go to RESP.
  - LATENCY>1: go to WAIT with cnt=LATENCY-1.
- WAIT: cnt decrements each cycle. When cnt==1, the next state is RESP.
- RESP without a handshake: return to IDLE.
- Writes commit to RAM at the handshake edge, only for bytes whose mask bit is set. A write with mask 0 still handshakes and returns data_ok.
- Reads capture the addressed word at the handshake edge into a response register.
  - A read accepted in the cycle right after a write to the same word returns the new data.
  - A write cannot overtake a pending read, since only one transaction is outstanding.
- For a write, mem_rdata is 0 during data_ok.
- mem_rdata is forced to 0 whenever mem_data_ok is 0.

## Timing
- Reset values: state IDLE, mem_data_ok 0, mem_rdata 0, cnt 0, stall LFSR at its seed. mem_addr_ok is 0 while rst_n is low.
- RAM contents are not reset.
- Handshake at edge N gives mem_data_ok high for exactly cycle N+LATENCY.
- Back-to-back throughput with LATENCY==1: one transaction per cycle. The arbiter re-requests in the data_ok cycle and is accepted there.
- Reset asserted mid-transaction: a pending response is dropped and no data_ok is issued. A write already committed remains in RAM.
- mem_req deasserted before handshake: nothing happens, and no state changes.

## Configuration
- RESP_STALL_EN: random backpressure injection for verification.
  - Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances every cycle. stall = lfsr[0], so mem_addr_ok is suppressed on stall cycles.
  - Undefined: stall is constant 0 and no LFSR is built.
- Latency and data semantics are identical in both modes.

## Test plan
- LATENCY=1: write 0xDEADBEEF to 0x10 with mask 4'hF, then read 0x10 -> addr_ok in both request cycles; data_ok one cycle after each handshake; read returns 0xDEADBEEF, write response rdata=0.
- Byte mask: preload 0x11223344 at 0x20, write 0xAABBCCDD with mask 4'b0101, read 0x20 -> 0x11BB33DD.
- Back-to-back: hold mem_req with reads of 0x0,0x4,0x8 (contents 1,2,3), re-requesting in each data_ok cycle -> addr_ok every cycle, data_ok on 3 consecutive cycles with 1,2,3.
- LATENCY=3: read at edge N -> data_ok only at N+3; addr_ok is 0 during N+1..N+2 even with mem_req high; addr_ok is available again at N+3.
- Alias: write 0x5A5A5A5A to 0x10 with DEPTH_LOG2=12, read address 0x4010 -> 0x5A5A5A5A.
- Reset mid-op with LATENCY=3: issue read, assert rst_n low for 1 cycle at N+1 -> no data_ok follows, outputs are 0, and the next request is accepted normally. With RESP_STALL_EN, 1000 random requests all complete, each with exactly one data_ok.
